cycle_sequencer: RTL and testbench
==================================

# cycle_sequencer

Instruction sequencer for the katp91 CPU core. It sits directly upstream of the control-signal decoder and supplies all of that decoder's inputs:
- the Gray-coded `cycle` count;
- the latched `operator_group` and `operator`;
- the registered `check_branch` decision.

It latches instruction bytes from the data bus at fixed fetch cycles. It ends each instruction at a group-dependent last cycle, evaluates branch conditions against the ALU flags, and honours a memory wait stall.

## Interface
Parameters:
- `LAST_EXT`, default 4'b1100 (CYCLE_8), last cycle of `GROUP_EXTENDED`.
- `LAST_STD`, default 4'b0111 (CYCLE_5), last cycle of the single-reg, math-constant, math-reg, reg-memory and stack groups.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous reset, active high.
- `wait_mem`  in  1  stall: while high, every register holds its value.
- `data_in`  in  8  memory read data.
- `flags`  in  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- `cycle`  out  4  Gray-coded cycle, CYCLE_0..CYCLE_15 encoding as used by the decoder.
- `operator_group`  out  4  opcode bits [7:4] of the current instruction.
- `operator`  out  4  opcode bits [3:0] of the current instruction.
- `regs`  out  8  second instruction byte (register fields).
- `check_branch`  out  1  taken-branch flag, valid during CYCLE_0.
- `illegal`  out  1  unknown-group indicator.

## Operation
Reset:
- `cycle`=CYCLE_0; `operator_group`, `operator` and `regs` = 0; `check_branch`=0; `illegal`=0.
- Reset takes priority over `wait_mem`.

Cycle counter:
- Advances one step per clock along the Gray order 0000→0001→0011→0010→0110→0111→0101→0100→1100→…→1000.
- Only Gray successor steps are legal; no binary-to-Gray conversion glitches on the output (it is a register).
- When `cycle` equals the current instruction's last cycle, the next value is CYCLE_0.

Last cycle per group (from the latched group):
- `GROUP_EXTENDED`: LAST_EXT.
- Standard groups: LAST_STD.
- `GROUP_BRANCH_JUMPS`: CYCLE_4.
- Any other group value: CYCLE_4 (illegal).
- CYCLE_15 (1000) always wraps to CYCLE_0 as a safety stop.

Latching:
- At the edge ending CYCLE_1: `regs` ← `data_in`.
- At the edge ending CYCLE_3: {`operator_group`, `operator`} ← `data_in`.
- Group and operator therefore hold the previous instruction through CYCLE_0..CYCLE_3. This is required because the decoder inspects the old group in CYCLE_0.

Branch evaluation, at the edge ending CYCLE_4 of a `GROUP_BRANCH_JUMPS` instruction:
- Condition select from `operator[2:0]`: 000→Z, 001→C, 010→N, 011→V, 1xx→1 (always).
- `operator[3]`=1 inverts the result.
- `check_branch` ← result.
- `check_branch` clears at the edge ending the following CYCLE_0. It is 0 in every other cycle.

Illegal:
- `illegal` is 1 exactly during CYCLE_4 of an instruction whose group is unknown; 0 otherwise.
- The sequencer then continues normally with the next fetch.

Stall:
- `wait_mem` high freezes `cycle`, all latches and `check_branch`.
- A latch scheduled on a stalled edge happens on the first non-stalled edge of that cycle.

## Timing
- Instruction length:
  - Standard groups: 6 clocks.
  - Branch/illegal: 5 clocks.
  - Extended with default parameter: 9 clocks.
  - Each stalled clock adds 1.
- Opcode visible to the decoder from CYCLE_4 onward, one clock after the read in CYCLE_3.
- `check_branch` has one-cycle validity: high only in the CYCLE_0 immediately after a taken branch.
- Reset mid-instruction: next cycle is CYCLE_0 with cleared opcode and `check_branch`=0, so the next fetch uses the normal PC path.
- Flags are sampled only at the end of branch CYCLE_4. Flag changes at other times are ignored.

## Test plan
- Reset then 12 clocks, `data_in`=standard-group opcode at CYCLE_3 → `cycle` sequence 0000,0001,0011,0010,0110,0111,0000,…; group and operator updated at the CYCLE_4 boundary.
- `GROUP_EXTENDED` opcode → `cycle` reaches 1100 (CYCLE_8) and then returns to 0000; `regs` equals the byte presented in CYCLE_1.
- Branch with `operator`=4'b0000 and Z=1 → `check_branch`=1 during the next CYCLE_0 only. With Z=0 → 0. With `operator`=4'b1000 and Z=0 → 1. With `operator`=4'b0100 → 1 regardless of flags.
- Unknown group → `illegal`=1 for one clock at CYCLE_4, then CYCLE_0.
- `wait_mem` held 3 clocks during CYCLE_3 → `cycle` stays 0010 for 4 clocks; opcode latched on release edge.
- `reset` asserted during CYCLE_5 of extended instruction → next clock `cycle`=0000, all outputs zero.

Source files
------------

// File: rtl/cycle_sequencer.sv
// Instruction sequencer: Gray-coded cycle counter, opcode/register latches,
// branch condition evaluation and illegal-group flag, all frozen by wait_mem.
module cycle_sequencer #(
  parameter logic [3:0] LAST_EXT = 4'b1100,
  parameter logic [3:0] LAST_STD = 4'b0111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wait_mem,
  input  logic [7:0] data_in,
  input  logic [3:0] flags,
  output logic [3:0] cycle,
  output logic [3:0] operator_group,
  output logic [3:0] operator,
  output logic [7:0] regs,
  output logic       check_branch,
  output logic       illegal
);

  localparam logic [3:0] CYCLE_0  = 4'b0000;
  localparam logic [3:0] CYCLE_1  = 4'b0001;
  localparam logic [3:0] CYCLE_2  = 4'b0011;
  localparam logic [3:0] CYCLE_3  = 4'b0010;
  localparam logic [3:0] CYCLE_4  = 4'b0110;
  localparam logic [3:0] CYCLE_5  = 4'b0111;
  localparam logic [3:0] CYCLE_6  = 4'b0101;
  localparam logic [3:0] CYCLE_7  = 4'b0100;
  localparam logic [3:0] CYCLE_8  = 4'b1100;
  localparam logic [3:0] CYCLE_9  = 4'b1101;
  localparam logic [3:0] CYCLE_10 = 4'b1111;
  localparam logic [3:0] CYCLE_11 = 4'b1110;
  localparam logic [3:0] CYCLE_12 = 4'b1010;
  localparam logic [3:0] CYCLE_13 = 4'b1011;
  localparam logic [3:0] CYCLE_14 = 4'b1001;
  localparam logic [3:0] CYCLE_15 = 4'b1000;

  localparam logic [3:0] GROUP_SINGLE_REG    = 4'd0;
  localparam logic [3:0] GROUP_MATH_CONST    = 4'd1;
  localparam logic [3:0] GROUP_MATH_REG      = 4'd2;
  localparam logic [3:0] GROUP_REG_MEMORY    = 4'd3;
  localparam logic [3:0] GROUP_STACK         = 4'd4;
  localparam logic [3:0] GROUP_BRANCH_JUMPS  = 4'd5;
  localparam logic [3:0] GROUP_EXTENDED      = 4'd6;

  logic [3:0] cycle_q, cycle_d;
  logic [3:0] group_q, group_d;
  logic [3:0] oper_q, oper_d;
  logic [7:0] regs_q, regs_d;
  logic       check_branch_q, check_branch_d;
  logic       illegal_q, illegal_d;
  logic [3:0] last_cycle;
  logic       cond_raw;
  logic       fetch_known;

  // Gray successor along the decoder's cycle order.
  function automatic logic [3:0] gray_next(input logic [3:0] g);
    logic [3:0] n;
    case (g)
      CYCLE_0:  n = CYCLE_1;
      CYCLE_1:  n = CYCLE_2;
      CYCLE_2:  n = CYCLE_3;
      CYCLE_3:  n = CYCLE_4;
      CYCLE_4:  n = CYCLE_5;
      CYCLE_5:  n = CYCLE_6;
      CYCLE_6:  n = CYCLE_7;
      CYCLE_7:  n = CYCLE_8;
      CYCLE_8:  n = CYCLE_9;
      CYCLE_9:  n = CYCLE_10;
      CYCLE_10: n = CYCLE_11;
      CYCLE_11: n = CYCLE_12;
      CYCLE_12: n = CYCLE_13;
      CYCLE_13: n = CYCLE_14;
      CYCLE_14: n = CYCLE_15;
      default:  n = CYCLE_0;
    endcase
    return n;
  endfunction

  function automatic logic group_is_known(input logic [3:0] g);
    return (g == GROUP_SINGLE_REG) || (g == GROUP_MATH_CONST) ||
           (g == GROUP_MATH_REG)   || (g == GROUP_REG_MEMORY) ||
           (g == GROUP_STACK)      || (g == GROUP_BRANCH_JUMPS) ||
           (g == GROUP_EXTENDED);
  endfunction

  // Last cycle of the current instruction, from the latched group.
  always_comb begin
    last_cycle = CYCLE_4;
    case (group_q)
      GROUP_EXTENDED:     last_cycle = LAST_EXT;
      GROUP_SINGLE_REG,
      GROUP_MATH_CONST,
      GROUP_MATH_REG,
      GROUP_REG_MEMORY,
      GROUP_STACK:        last_cycle = LAST_STD;
      default:            last_cycle = CYCLE_4;
    endcase
  end

  always_comb begin
    cond_raw = 1'b1;
    case (oper_q[2:0])
      3'b000:  cond_raw = flags[0];
      3'b001:  cond_raw = flags[1];
      3'b010:  cond_raw = flags[2];
      3'b011:  cond_raw = flags[3];
      default: cond_raw = 1'b1;
    endcase
  end

  assign fetch_known = group_is_known(data_in[7:4]);

  // Next-state: everything holds while memory stalls.
  always_comb begin
    cycle_d        = cycle_q;
    group_d        = group_q;
    oper_d         = oper_q;
    regs_d         = regs_q;
    check_branch_d = check_branch_q;
    illegal_d      = illegal_q;
    if (!wait_mem) begin
      if ((cycle_q == last_cycle) || (cycle_q == CYCLE_15)) begin
        cycle_d = CYCLE_0;
      end else begin
        cycle_d = gray_next(cycle_q);
      end
      check_branch_d = (cycle_q == CYCLE_4) && (group_q == GROUP_BRANCH_JUMPS) &&
                       (cond_raw ^ oper_q[3]);
      illegal_d      = (cycle_q == CYCLE_3) && !fetch_known;
      if (cycle_q == CYCLE_1) begin
        regs_d = data_in;
      end
      if (cycle_q == CYCLE_3) begin
        group_d = data_in[7:4];
        oper_d  = data_in[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q        <= CYCLE_0;
      group_q        <= 4'd0;
      oper_q         <= 4'd0;
      regs_q         <= 8'd0;
      check_branch_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      cycle_q        <= cycle_d;
      group_q        <= group_d;
      oper_q         <= oper_d;
      regs_q         <= regs_d;
      check_branch_q <= check_branch_d;
      illegal_q      <= illegal_d;
    end
  end

  assign cycle          = cycle_q;
  assign operator_group = group_q;
  assign operator       = oper_q;
  assign regs           = regs_q;
  assign check_branch   = check_branch_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed vector table, per-instruction sequences
// and randomized traffic, all checked against an index-based reference model.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wait_mem = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [3:0] flags = 4'd0;
  logic [3:0] cycle, operator_group, operator;
  logic [7:0] regs;
  logic       check_branch, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  cycle_sequencer dut (
    .clk(clk), .reset(reset), .wait_mem(wait_mem), .data_in(data_in), .flags(flags),
    .cycle(cycle), .operator_group(operator_group), .operator(operator), .regs(regs),
    .check_branch(check_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model: instruction position as a plain step index.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};
  int         m_idx = 0;
  logic [3:0] m_grp = 4'd0, m_op = 4'd0;
  logic [7:0] m_regs = 8'd0;
  logic       m_cb = 1'b0, m_ill = 1'b0;

  function automatic int last_idx(input logic [3:0] g);
    if (g == 4'd6) return 8;
    if (g <= 4'd4) return 5;
    return 4;
  endfunction

  function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] f);
    logic c;
    if (op[2]) c = 1'b1;
    else c = f[op[1:0]];
    return c ^ op[3];
  endfunction

  task automatic model_clock(input logic r, input logic w, input logic [7:0] d,
                             input logic [3:0] f);
    int nxt;
    if (r) begin
      m_idx = 0; m_grp = 0; m_op = 0; m_regs = 0; m_cb = 0; m_ill = 0;
    end else if (!w) begin
      nxt   = (m_idx == last_idx(m_grp) || m_idx == 15) ? 0 : m_idx + 1;
      m_cb  = (m_idx == 4 && m_grp == 4'd5) ? branch_taken(m_op, f) : 1'b0;
      m_ill = (m_idx == 3) && (d[7:4] > 4'd6);
      if (m_idx == 1) m_regs = d;
      if (m_idx == 3) begin
        m_grp = d[7:4];
        m_op  = d[3:0];
      end
      m_idx = nxt;
    end
  endtask

  function automatic logic [21:0] pack(input logic [3:0] c, input logic [3:0] g,
                                       input logic [3:0] o, input logic [7:0] rg,
                                       input logic cb, input logic il);
    return {c, g, o, rg, cb, il};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] dut_vec();
    return pack(cycle, operator_group, operator, regs, check_branch, illegal);
  endfunction

  // One clock: drive on negedge, update model on posedge, compare 1 time unit later.
  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic [3:0] f, input string tag);
    @(negedge clk);
    reset = r; wait_mem = w; data_in = d; flags = f;
    @(posedge clk);
    model_clock(r, w, d, f);
    #1;
    check(tag, 32'(dut_vec()), 32'(pack(gray_tab[m_idx], m_grp, m_op, m_regs, m_cb, m_ill)));
  endtask

  int len_clocks, ill_cnt, c3_cnt;
  logic seen_c8;

  // Runs one whole instruction from CYCLE_0, optionally stalling 3 clocks in CYCLE_3.
  task automatic run_instr(input logic [7:0] rb, input logic [7:0] opc,
                           input logic [3:0] f, input logic stall);
    int stalls_left;
    logic [7:0] d;
    logic w;
    stalls_left = stall ? 3 : 0;
    len_clocks = 0; ill_cnt = 0; c3_cnt = 0; seen_c8 = 1'b0;
    do begin
      d = (m_idx == 1) ? rb : (m_idx == 3) ? opc : 8'($urandom);
      w = (m_idx == 3) && (stalls_left > 0);
      if (w) stalls_left--;
      step(1'b0, w, d, f, "instr");
      len_clocks++;
      if (illegal) ill_cnt++;
      if (cycle == 4'b0010) c3_cnt++;
      if (cycle == 4'b1100) seen_c8 = 1'b1;
    end while (m_idx != 0 && len_clocks < 30);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [7:0]  d;
    logic [3:0]  f;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 4'h0, pack(4'b0000, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0)};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0001, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 4'h0, pack(4'b0011, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0010, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b0, 8'h12, 4'h0, pack(4'b0110, 4'h1, 4'h2, 8'hA5, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0111, 4'h1, 4'h2, 8'hA5, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0000, 4'h1, 4'h2, 8'hA5, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0001, 4'h1, 4'h2, 8'hA5, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b0, 8'h3C, 4'h0, pack(4'b0011, 4'h1, 4'h2, 8'h3C, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0010, 4'h1, 4'h2, 8'h3C, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b0, 8'h50, 4'h0, pack(4'b0110, 4'h5, 4'h0, 8'h3C, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 4'h1, pack(4'b0000, 4'h5, 4'h0, 8'h3C, 1'b1, 1'b0)};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0001, 4'h5, 4'h0, 8'h3C, 1'b0, 1'b0)};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0011, 4'h5, 4'h0, 8'h00, 1'b0, 1'b0)};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0010, 4'h5, 4'h0, 8'h00, 1'b0, 1'b0)};
    tbl[15] = '{1'b0, 1'b0, 8'hF7, 4'h0, pack(4'b0110, 4'hF, 4'h7, 8'h00, 1'b0, 1'b1)};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0000, 4'hF, 4'h7, 8'h00, 1'b0, 1'b0)};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 4'h0, pack(4'b0001, 4'hF, 4'h7, 8'h00, 1'b0, 1'b0)};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].f, "model_tbl");
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // Per-instruction sequences from a clean CYCLE_0.
    step(1'b1, 1'b0, 8'h00, 4'h0, "rst");
    run_instr(8'h11, 8'h23, 4'h0, 1'b0);
    check("len_std", 32'(len_clocks), 32'd6);
    check("grp_std", 32'(operator_group), 32'h2);
    run_instr(8'h9E, 8'h6A, 4'h0, 1'b0);
    check("len_ext", 32'(len_clocks), 32'd9);
    check("ext_c8", 32'(seen_c8), 32'd1);
    check("ext_regs", 32'(regs), 32'h9E);
    run_instr(8'h01, 8'h50, 4'h1, 1'b0);
    check("len_br", 32'(len_clocks), 32'd5);
    check("br_z1", 32'(check_branch), 32'd1);
    run_instr(8'h02, 8'h50, 4'hE, 1'b0);
    check("br_z0", 32'(check_branch), 32'd0);
    run_instr(8'h03, 8'h58, 4'h0, 1'b0);
    check("br_nz", 32'(check_branch), 32'd1);
    run_instr(8'h04, 8'h54, 4'h0, 1'b0);
    check("br_always0", 32'(check_branch), 32'd1);
    run_instr(8'h05, 8'h54, 4'hF, 1'b0);
    check("br_always1", 32'(check_branch), 32'd1);
    run_instr(8'h06, 8'hF3, 4'h0, 1'b0);
    check("len_ill", 32'(len_clocks), 32'd5);
    check("ill_cnt", 32'(ill_cnt), 32'd1);
    run_instr(8'h33, 8'h12, 4'h0, 1'b1);
    check("len_stall", 32'(len_clocks), 32'd9);
    check("stall_c3", 32'(c3_cnt), 32'd4);
    check("stall_op", 32'({operator_group, operator}), 32'h12);

    // Reset while an extended instruction sits in CYCLE_5.
    for (int k = 0; k < 10 && m_idx != 5; k++) begin
      step(1'b0, 1'b0, (m_idx == 3) ? 8'h6B : 8'h44, 4'h0, "pre_rst");
    end
    check("at_c5", 32'(cycle), 32'b0111);
    step(1'b1, 1'b0, 8'hFF, 4'hF, "mid_rst");
    check("mid_rst_all", 32'(dut_vec()), 32'd0);

    // Randomized traffic with stalls and occasional resets.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
           8'($urandom), 4'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
